// File: rtl/card_pair_picker.sv
// Memory-game pair picker: two button selects reveal two cards, then the pair resolves as a match or a miss.
// Optional macro CARD_PICK_TIMEOUT_EN abandons a lone first pick after 2^16 idle cycles.
module card_pair_picker #(
   parameter  int NUM_CARDS   = 16,
   parameter  int FACE_W      = 3,
   parameter  int SHOW_CYCLES = 8,
   localparam int IDX_W       = $clog2(NUM_CARDS + 1)
) (
   input  logic                 new_clk,
   input  logic                 rst,
   input  logic                 north,
   input  logic [IDX_W-1:0]     point,
   input  logic [FACE_W-1:0]    face,
   output logic [IDX_W-1:0]     choose_1,
   output logic [IDX_W-1:0]     choose_2,
   output logic                 C2,
   output logic                 match_p,
   output logic                 miss_p,
   output logic [NUM_CARDS-1:0] matched_mask,
   output logic [IDX_W-1:0]     pairs,
   output logic                 all_done
);

   localparam logic [IDX_W-1:0]     NONE    = IDX_W'(NUM_CARDS);
   localparam logic [IDX_W-1:0]     HALF    = IDX_W'(NUM_CARDS / 2);
   localparam logic [7:0]           SHOW_LD = 8'(SHOW_CYCLES);
   localparam logic [NUM_CARDS-1:0] ONE_BIT = {{(NUM_CARDS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, ONE, SHOW, RESOLVE} state_t;

   state_t              state;
   logic                north_q;
   logic [FACE_W-1:0]   face1, face2;
   logic [7:0]          show_cnt;
`ifdef CARD_PICK_TIMEOUT_EN
   logic [15:0]         tmo_cnt;
`endif

   logic                sel_ok;
   logic [NUM_CARDS-1:0] mask_sh;
   logic [NUM_CARDS-1:0] hit1, hit2;

   // A select is a fresh press on an on-board card that is still face down.
   always_comb begin
      mask_sh = matched_mask >> point;
      sel_ok  = north && !north_q && (point < NONE) && !mask_sh[0] && !all_done;
      hit1    = ONE_BIT << choose_1;
      hit2    = ONE_BIT << choose_2;
   end

   // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
   always_ff @(posedge new_clk) begin
      if (rst) begin
         state        <= IDLE;
         north_q      <= 1'b1;
         face1        <= '0;
         face2        <= '0;
         show_cnt     <= '0;
         choose_1     <= NONE;
         choose_2     <= NONE;
         C2           <= 1'b0;
         match_p      <= 1'b0;
         miss_p       <= 1'b0;
         matched_mask <= '0;
         pairs        <= '0;
         all_done     <= 1'b0;
`ifdef CARD_PICK_TIMEOUT_EN
         tmo_cnt      <= '0;
`endif
      end else begin
         north_q  <= north;
         match_p  <= 1'b0;
         miss_p   <= 1'b0;
         all_done <= all_done | (pairs == HALF);
         case (state)
            IDLE: begin
               if (sel_ok) begin
                  choose_1 <= point;
                  face1    <= face;
                  state    <= ONE;
`ifdef CARD_PICK_TIMEOUT_EN
                  tmo_cnt  <= '0;
`endif
               end
            end
            ONE: begin
               if (sel_ok && point != choose_1) begin
                  choose_2 <= point;
                  face2    <= face;
                  show_cnt <= SHOW_LD;
                  C2       <= 1'b1;
                  state    <= SHOW;
               end
`ifdef CARD_PICK_TIMEOUT_EN
               else if (tmo_cnt == 16'hFFFF) begin
                  choose_1 <= NONE;
                  state    <= IDLE;
               end else begin
                  tmo_cnt  <= tmo_cnt + 16'd1;
               end
`endif
            end
            SHOW: begin
               // Last revealed cycle: the pulse is registered so it is high for the whole RESOLVE cycle.
               if (show_cnt <= 8'd1) begin
                  C2    <= 1'b0;
                  state <= RESOLVE;
                  if (face1 == face2) match_p <= 1'b1;
                  else                miss_p  <= 1'b1;
               end else begin
                  show_cnt <= show_cnt - 8'd1;
               end
            end
            RESOLVE: begin
               if (face1 == face2) begin
                  matched_mask <= matched_mask | hit1 | hit2;
                  if (pairs < HALF) pairs <= pairs + 1'b1;
               end
               choose_1 <= NONE;
               choose_2 <= NONE;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_card_pair_picker.sv
// Directed self-checking bench for card_pair_picker at default parameters (16 cards, 8 show cycles).
module tb_card_pair_picker;

   localparam int IDX_W = 5;

   logic             new_clk = 1'b0;
   logic             rst;
   logic             north;
   logic [IDX_W-1:0] point;
   logic [2:0]       face;
   logic [IDX_W-1:0] choose_1, choose_2, pairs;
   logic             C2, match_p, miss_p, all_done;
   logic [15:0]      matched_mask;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_mask;
   logic [4:0]  exp_pairs;

   card_pair_picker dut (
      .new_clk      (new_clk),
      .rst          (rst),
      .north        (north),
      .point        (point),
      .face         (face),
      .choose_1     (choose_1),
      .choose_2     (choose_2),
      .C2           (C2),
      .match_p      (match_p),
      .miss_p       (miss_p),
      .matched_mask (matched_mask),
      .pairs        (pairs),
      .all_done     (all_done)
   );

   always #5 new_clk = ~new_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One press: north high for one cycle, then low for one cycle.
   task automatic select(input logic [IDX_W-1:0] p, input logic [2:0] f);
      point = p;
      face  = f;
      north = 1'b1;
      @(negedge new_clk);
      north = 1'b0;
      @(negedge new_clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " choose_1"}, choose_1, 16);
      check({tag, " choose_2"}, choose_2, 16);
      check({tag, " C2"}, C2, 0);
      check({tag, " pulses"}, {match_p, miss_p}, 0);
      check({tag, " mask"}, matched_mask, 0);
      check({tag, " pairs"}, pairs, 0);
      check({tag, " all_done"}, all_done, 0);
   endtask

   // Second pick plus full observation of the SHOW/RESOLVE window.
   task automatic finish_pair(input string tag, input logic [IDX_W-1:0] p1,
                              input logic [IDX_W-1:0] p2, input logic [2:0] f2,
                              input bit expect_match);
      int c2n, mn, msn, both;
      logic [15:0] old_mask, mask_at_pulse;
      old_mask = exp_mask;
      point = p2;
      face  = f2;
      north = 1'b1;
      @(negedge new_clk);
      north = 1'b0;
      check({tag, " choose_2"}, choose_2, 32'(p2));
      c2n = 0; mn = 0; msn = 0; both = 0;
      mask_at_pulse = matched_mask;
      for (int i = 0; i < 20; i++) begin
         if (C2) c2n++;
         if (match_p) begin mn++; mask_at_pulse = matched_mask; end
         if (miss_p) msn++;
         if (match_p && miss_p) both++;
         @(negedge new_clk);
      end
      if (expect_match) begin
         exp_mask = exp_mask | (16'd1 << p1) | (16'd1 << p2);
         if (exp_pairs < 5'd8) exp_pairs = exp_pairs + 5'd1;
      end
      check({tag, " C2 cycles"}, c2n, 8);
      check({tag, " match_p count"}, mn, expect_match ? 1 : 0);
      check({tag, " miss_p count"}, msn, expect_match ? 0 : 1);
      check({tag, " pulses overlap"}, both, 0);
      check({tag, " mask during resolve"}, mask_at_pulse, old_mask);
      check({tag, " choose_1 cleared"}, choose_1, 16);
      check({tag, " choose_2 cleared"}, choose_2, 16);
      check({tag, " mask"}, matched_mask, exp_mask);
      check({tag, " pairs"}, pairs, exp_pairs);
   endtask

   initial begin
      int mn, msn;
      rst = 1'b1; north = 1'b0; point = '0; face = '0;
      exp_mask = '0; exp_pairs = '0;
      repeat (3) @(negedge new_clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge new_clk);

      // Matching pair 3/7, face 5.
      select(5'd3, 3'd5);
      check("t1 choose_1", choose_1, 3);
      check("t1 C2 before second", C2, 0);
      finish_pair("t1", 5'd3, 5'd7, 3'd5, 1'b1);
      check("t1 mask value", matched_mask, 16'h0088);

      // Mismatch 2 (face 1) / 9 (face 4).
      select(5'd2, 3'd1);
      finish_pair("t2", 5'd2, 5'd9, 3'd4, 1'b0);

      // Ignored selects while holding card 5.
      select(5'd5, 3'd2);
      check("t3 choose_1", choose_1, 5);
      select(5'd5, 3'd2);
      check("t3 same card choose_2", choose_2, 16);
      check("t3 same card C2", C2, 0);
      select(5'd3, 3'd5);
      check("t3 matched card choose_2", choose_2, 16);
      select(5'd20, 3'd0);
      check("t3 off board choose_2", choose_2, 16);
      check("t3 still holding 5", choose_1, 5);
      check("t3 no pulses", {match_p, miss_p}, 0);
      finish_pair("t3", 5'd5, 5'd0, 3'd2, 1'b1);
      check("t3 mask value", matched_mask, 16'h00A9);

      // Held button: one event only, even when the cursor moves while held.
      point = 5'd4; face = 3'd3; north = 1'b1;
      repeat (50) @(negedge new_clk);
      check("t4 held choose_1", choose_1, 4);
      point = 5'd6;
      repeat (5) @(negedge new_clk);
      check("t4 held no second pick", choose_2, 16);
      check("t4 held C2", C2, 0);
      north = 1'b0;
      @(negedge new_clk);
      select(5'd6, 3'd1);
      check("t4 in SHOW", C2, 1);
      // Reset mid-SHOW with north held through it.
      rst = 1'b1; north = 1'b1; point = 5'd8;
      @(negedge new_clk);
      check_reset_vals("t4 mid-show reset");
      rst = 1'b0;
      repeat (3) @(negedge new_clk);
      check("t4 held through reset no event", choose_1, 16);
      north = 1'b0;
      @(negedge new_clk);
      exp_mask = '0; exp_pairs = '0;

      // Clear the whole board: pair (2k, 2k+1) shares face k.
      for (int k = 0; k < 8; k++) begin
         if (k == 7) check("t5 all_done before last", all_done, 0);
         select(5'(2 * k), 3'(k));
         finish_pair("t5", 5'(2 * k), 5'(2 * k + 1), 3'(k), 1'b1);
      end
      check("t5 pairs", pairs, 8);
      check("t5 all_done", all_done, 1);
      check("t5 mask full", matched_mask, 16'hFFFF);
      select(5'd2, 3'd1);
      check("t5 select after done", choose_1, 16);
      check("t5 all_done sticky", all_done, 1);

      // Lone first pick left waiting.
      rst = 1'b1;
      @(negedge new_clk);
      rst = 1'b0;
      @(negedge new_clk);
      select(5'd6, 3'd1);
      check("t6 choose_1", choose_1, 6);
      mn = 0; msn = 0;
      for (int i = 0; i < 65600; i++) begin
         if (match_p) mn++;
         if (miss_p) msn++;
         @(negedge new_clk);
      end
      check("t6 no match_p", mn, 0);
      check("t6 no miss_p", msn, 0);
`ifdef CARD_PICK_TIMEOUT_EN
      check("t6 timeout choose_1", choose_1, 16);
      select(5'd9, 3'd2);
      check("t6 back in IDLE", choose_1, 9);
`else
      check("t6 waits choose_1", choose_1, 6);
      check("t6 waits choose_2", choose_2, 16);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/card_pair_picker.md
CARD_PAIR_PICKER -- requirements
Module: card_pair_picker

Interface
REQ-001 SHALL have parameter NUM_CARDS, default 16, number of cards on the board (even, 4..64).
REQ-002 SHALL have parameter FACE_W, default 3, width of a card face value.
REQ-003 SHALL have parameter SHOW_CYCLES, default 8, cycles both picked cards stay revealed before resolve (1..255).
REQ-004 SHALL have derived localparam IDX_W = clog2(NUM_CARDS+1); index value NUM_CARDS is the "none" sentinel.
REQ-005 SHALL have port new_clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port north  input  1  select button level, already debounced, synchronous to new_clk.
REQ-008 SHALL have port point  input  IDX_W  card index under the cursor.
REQ-009 SHALL have port face  input  FACE_W  face value of card at point, valid in the same cycle.
REQ-010 SHALL have port choose_1  output  IDX_W  first picked index, NUM_CARDS when none.
REQ-011 SHALL have port choose_2  output  IDX_W  second picked index, NUM_CARDS when none.
REQ-012 SHALL have port C2  output  1  high while two cards are held (SHOW state).
REQ-013 SHALL have port match_p / miss_p  output  1 each  one-cycle resolve pulses.
REQ-014 SHALL have port matched_mask  output  NUM_CARDS  bit i set when card i is removed.
REQ-015 SHALL have port pairs  output  IDX_W  count of matched pairs.
REQ-016 SHALL have port all_done  output  1  high when pairs == NUM_CARDS/2.

Function
REQ-017 SHALL detect a select event as north rising edge (north=1, previous-cycle north=0); a held level SHALL produce one event only.
REQ-018 SHALL implement FSM states IDLE, ONE, SHOW, RESOLVE.
REQ-019 IDLE: valid select -> latch choose_1=point, face1=face, go ONE next cycle.
REQ-020 ONE: valid select with point != choose_1 -> latch choose_2=point, face2=face, load show counter SHOW_CYCLES, go SHOW.
REQ-021 A select SHALL be ignored (no state or output change) when point >= NUM_CARDS, matched_mask[point]=1, point == choose_1, state is SHOW/RESOLVE, or all_done=1.
REQ-022 SHOW: C2=1; counter decrements each cycle; at 0 go RESOLVE; selects ignored.
REQ-023 RESOLVE (one cycle): if face1 == face2 assert match_p, set both matched_mask bits, pairs += 1; else assert miss_p; choose_1/choose_2 return to NUM_CARDS; go IDLE.
REQ-024 match_p and miss_p SHALL never be high together and SHALL be high exactly one cycle per resolve.
REQ-025 Latency: select edge to choose_1/choose_2 update = 1 cycle; C2 high exactly SHOW_CYCLES cycles; pairs/matched_mask updated in the cycle after RESOLVE.
REQ-026 pairs SHALL saturate at NUM_CARDS/2; all_done SHALL be registered from pairs and stay high until reset.

Reset
REQ-027 rst=1 at any clock edge, including mid-SHOW, SHALL force IDLE, choose_1=choose_2=NUM_CARDS, C2=0, match_p=miss_p=0, matched_mask=0, pairs=0, all_done=0, edge-detect history=1 (north held through reset yields no event).
REQ-028 rst SHALL take priority over every select and counter event in the same cycle.

Configuration
REQ-029 Macro CARD_PICK_TIMEOUT_EN defined: in ONE, a counter of 2^16 cycles without a valid second select SHALL clear choose_1 to NUM_CARDS and return to IDLE without match_p/miss_p.
REQ-030 Macro CARD_PICK_TIMEOUT_EN undefined: ONE SHALL wait indefinitely; no timeout counter SHALL be synthesised.

Verification
REQ-031 Reset then north edge at point=3 face=5, edge at point=7 face=5 -> choose_1=3, choose_2=7, C2 high 8 cycles, match_p once, matched_mask=0x0088, pairs=1.
REQ-032 Picks 2 (face 1) then 9 (face 4) -> miss_p once, mask unchanged, choose_1/choose_2 back to 16.
REQ-033 Pick 5 then 5 again, then pick matched card 3, then point=20 -> all ignored, state stays ONE, choose_2=16.
REQ-034 north held high 50 cycles at point=4 -> exactly one event, choose_1=4; rst asserted during SHOW -> all outputs at reset values next cycle.
REQ-035 Match all 8 pairs -> pairs=8, all_done=1, further selects ignored.
REQ-036 With CARD_PICK_TIMEOUT_EN: pick 6 then idle 65536 cycles -> choose_1=16, state IDLE, no match_p/miss_p; without macro choose_1 stays 6.
